jtframe_dwnld_buf: RTL and testbench

Download-side buffer feeding the SDRAM programming port of jtframe_mist.
- Accepts the byte stream from the SPI I/O controller (ioctl_addr/ioctl_data/ioctl_wr).
- Strips an optional file header and diverts the PROM region to a separate strobe.
- Queues SDRAM bytes in a small FIFO and drains them one at a time through a prog_we/prog_rdy handshake, so SDRAM refresh stalls never lose bytes.

---
 rtl/jtframe_dwnld_buf.sv | 131 +++++++++++++
 tb/tb_jtframe_dwnld_buf.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dwnld_buf.sv
// Download buffer: strips the file header, diverts the PROM region to its own
// strobe and queues SDRAM bytes in a FIFO drained through a prog_we/prog_rdy handshake.
module jtframe_dwnld_buf #(
  parameter int          SDRAMW     = 22,
  parameter int          HEADER     = 0,
  parameter logic [24:0] PROM_START = 25'h1FF_FFFF,
  parameter int          FIFO_AW    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              prom_we,
  output logic [15:0]       prom_addr,
  output logic [7:0]        prom_data,
  output logic              dwnld_busy,
  output logic              overflow
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int EW    = SDRAMW + 1 + 8;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;
  state_t state, state_nx;

  logic [25:0]        eff_full;
  logic [24:0]        eff;
  logic               in_hdr, in_ok, prom_hit;
  logic               push, pop, push_ok, full, empty, dl_q;
  logic [EW-1:0]      mem [DEPTH];
  logic [EW-1:0]      head;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [15:0]        prom_off;

  // The borrow of the subtraction flags header bytes without a constant compare
  assign eff_full = {1'b0, ioctl_addr} - 26'(HEADER);
  assign in_hdr   = eff_full[25];
  assign eff      = eff_full[24:0];
  assign prom_hit = eff >= PROM_START;
  assign prom_off = eff[15:0] - PROM_START[15:0];

  assign in_ok   = downloading & ioctl_wr & ~in_hdr;
  assign push    = in_ok & ~prom_hit;
  assign empty   = count == '0;
  assign full    = count == (FIFO_AW+1)'(DEPTH);
  assign pop     = (state == WRITE) & prog_rdy;
  assign push_ok = push & (~full | pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {eff[SDRAMW:0], ioctl_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dl_q     <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a new download start still gets reported
      if (downloading & ~dl_q) overflow <= 1'b0;
      if (push & ~push_ok)     overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = WRITE;
      WRITE:   if (prog_rdy) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_addr  <= '0;
      prog_data  <= '0;
      prog_mask  <= 2'b11;
      prog_we    <= 1'b0;
      prom_we    <= 1'b0;
      prom_addr  <= '0;
      prom_data  <= '0;
      dwnld_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          prog_addr <= head[EW-1:9];
          prog_data <= {2{head[7:0]}};
          prog_mask <= head[8] ? 2'b01 : 2'b10;
          prog_we   <= 1'b1;
        end
        WRITE: if (prog_rdy) begin
          prog_we   <= 1'b0;
          prog_mask <= 2'b11;
        end
        default: ;
      endcase
      prom_we <= in_ok & prom_hit;
      if (in_ok & prom_hit) begin
        prom_addr <= prom_off;
        prom_data <= ioctl_data;
      end
      dwnld_busy <= downloading | ~empty | (state != IDLE);
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_buf.sv
// Bench for jtframe_dwnld_buf: queue-based model of the byte routing plus
// directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_jtframe_dwnld_buf;
  localparam int          SDRAMW = 22;
  localparam int          HDR    = 2;
  localparam int          FAW    = 3;
  localparam int          DEPTH  = 8;
  localparam logic [24:0] PSTART = 25'h8000;

  logic              clk = 1'b0, rst_n = 1'b0, downloading = 1'b0;
  logic              ioctl_wr = 1'b0, prog_rdy = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_data = '0;
  logic [SDRAMW-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [1:0]        prog_mask;
  logic              prog_we, prom_we, dwnld_busy, overflow;
  logic [15:0]       prom_addr;
  logic [7:0]        prom_data;

  jtframe_dwnld_buf #(
    .SDRAMW(SDRAMW), .HEADER(HDR), .PROM_START(PSTART), .FIFO_AW(FAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_rdy(prog_rdy),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
    .dwnld_busy(dwnld_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [24:0] eff; logic [7:0] b; } ent_t;
  typedef struct { logic [SDRAMW-1:0] a; logic [15:0] d; logic [1:0] m; } wr_t;

  ent_t        q[$];
  wr_t         wlog[$];
  int          errors = 0, checks = 0;
  bit          m_ov = 0, m_prom_we = 0, dl_prev = 0, hold = 0;
  logic [15:0] m_prom_addr = '0;
  logic [7:0]  m_prom_data = '0;
  int          rdy_delay = 1, wcnt = 0, idle_run = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Spec-level model: FIFO contents as a queue, updated at the active edge
  task automatic model_step();
    ent_t e;
    wr_t  w;
    logic [24:0] eff;
    if (prog_we && prog_rdy) begin
      w.a = prog_addr; w.d = prog_data; w.m = prog_mask;
      wlog.push_back(w);
      if (q.size() > 0) void'(q.pop_front());
    end
    if (downloading && !dl_prev) m_ov = 0;
    dl_prev   = downloading;
    m_prom_we = 0;
    if (downloading && ioctl_wr && ioctl_addr >= 25'(HDR)) begin
      eff = ioctl_addr - 25'(HDR);
      if (eff >= PSTART) begin
        m_prom_we   = 1;
        m_prom_addr = 16'(eff - PSTART);
        m_prom_data = ioctl_data;
      end else if (q.size() < DEPTH) begin
        e.eff = eff; e.b = ioctl_data;
        q.push_back(e);
      end else begin
        m_ov = 1;
      end
    end
  endtask

  task automatic compare();
    ent_t h;
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("prom_we", 32'(prom_we), 32'(m_prom_we));
    if (m_prom_we) begin
      chk("prom_addr", 32'(prom_addr), 32'(m_prom_addr));
      chk("prom_data", 32'(prom_data), 32'(m_prom_data));
    end
    if (prog_we) begin
      chk("prog_we_queue_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        h = q[0];
        chk("prog_addr", 32'(prog_addr), 32'(h.eff[SDRAMW:1]));
        chk("prog_data", 32'(prog_data), 32'({2{h.b}}));
        chk("prog_mask", 32'(prog_mask), 32'(h.eff[0] ? 2'b01 : 2'b10));
      end
    end else begin
      chk("prog_mask_idle", 32'(prog_mask), 32'd3);
    end
    if (q.size() > 0 && !prog_we) idle_run++;
    else idle_run = 0;
    chk("drain_latency", 32'(idle_run <= 2), 32'd1);
  endtask

  // Called at a falling edge: SDRAM responder, then drive, then model and check
  task automatic cyc(input bit wr, input logic [24:0] a, input logic [7:0] d, input bit frc);
    if (prog_rdy) begin
      prog_rdy = 1'b0;
      wcnt = 0;
    end else if (prog_we && (frc || (!hold && wcnt >= rdy_delay))) begin
      prog_rdy = 1'b1;
    end else if (prog_we && !hold) begin
      wcnt++;
    end
    ioctl_wr = wr; ioctl_addr = a; ioctl_data = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 25'd0, 8'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    bit  done;
    bit  ovs[12];

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_prog_we", 32'(prog_we), 32'd0);
    chk("rst_prog_mask", 32'(prog_mask), 32'd3);
    chk("rst_prog_addr", 32'(prog_addr), 32'd0);
    chk("rst_prog_data", 32'(prog_data), 32'd0);
    chk("rst_busy", 32'(dwnld_busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_prom_we", 32'(prom_we), 32'd0);
    chk("rst_prom_addr", 32'(prom_addr), 32'd0);
    chk("rst_prom_data", 32'(prom_data), 32'd0);
    rst_n = 1'b1;

    // Header stripping: two header bytes, then two bytes into one SDRAM word
    downloading = 1'b1;
    cyc(1'b1, 25'd0, 8'hAA, 1'b0);
    cyc(1'b1, 25'd1, 8'hBB, 1'b0);
    chk("hdr_no_write", 32'(prog_we), 32'd0);
    cyc(1'b1, 25'd2, 8'h11, 1'b0);
    chk("we_not_same_cycle", 32'(prog_we), 32'd0);
    cyc(1'b1, 25'd3, 8'h22, 1'b0);
    chk("we_cycle_after_push", 32'(prog_we), 32'd1);
    chk("first_addr", 32'(prog_addr), 32'd0);
    chk("first_data", 32'(prog_data), 32'h1111);
    chk("first_mask", 32'(prog_mask), 32'd2);
    idle(20);
    chk("hdr_write_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() >= 2) begin
      chk("second_addr", 32'(wlog[1].a), 32'd0);
      chk("second_data", 32'(wlog[1].d), 32'h2222);
      chk("second_mask", 32'(wlog[1].m), 32'd1);
    end

    // PROM region
    base = wlog.size();
    cyc(1'b1, 25'h8005, 8'h5C, 1'b0);
    chk("prom_pulse", 32'(prom_we), 32'd1);
    chk("prom_addr_lit", 32'(prom_addr), 32'd3);
    chk("prom_data_lit", 32'(prom_data), 32'h5C);
    cyc(1'b0, 25'd0, 8'd0, 1'b0);
    chk("prom_one_cycle", 32'(prom_we), 32'd0);
    chk("prom_no_prog_we", 32'(prog_we), 32'd0);
    chk("prom_no_write", 32'(wlog.size() - base), 32'd0);

    // Overflow: 12 bytes against a stalled SDRAM
    base = wlog.size();
    hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 25'h10 + 25'(i), 8'h30 + 8'(i), 1'b0);
      ovs[i] = overflow;
    end
    chk("ovf_after_8th", 32'(ovs[7]), 32'd0);
    chk("ovf_after_9th", 32'(ovs[8]), 32'd1);
    idle(28);
    chk("ovf_held_no_write", 32'(wlog.size() - base), 32'd0);
    hold = 1'b0;
    idle(60);
    chk("ovf_write_count", 32'(wlog.size() - base), 32'd8);
    for (int k = 0; k < 8; k++)
      if (base + k < wlog.size())
        chk("ovf_order", 32'(wlog[base + k].d), 32'({2{8'h30 + 8'(k)}}));
    chk("ovf_sticky", 32'(overflow), 32'd1);
    downloading = 1'b0;
    cyc(1'b0, 25'd0, 8'd0, 1'b0);
    chk("ovf_sticky_dl_low", 32'(overflow), 32'd1);
    downloading = 1'b1;
    cyc(1'b0, 25'd0, 8'd0, 1'b0);
    chk("ovf_clear_on_rise", 32'(overflow), 32'd0);

    // Push into a full FIFO on the popping edge
    base = wlog.size();
    hold = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 25'h100 + 25'(i), 8'h50 + 8'(i), 1'b0);
    cyc(1'b1, 25'h108, 8'h58, 1'b1);
    chk("full_pop_push_no_ovf", 32'(overflow), 32'd0);
    hold = 1'b0;
    idle(70);
    chk("full_pop_count", 32'(wlog.size() - base), 32'd9);
    for (int k = 0; k < 9; k++)
      if (base + k < wlog.size())
        chk("full_pop_order", 32'(wlog[base + k].d), 32'({2{8'h50 + 8'(k)}}));

    // dwnld_busy after downloading falls with three bytes queued
    base = wlog.size();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 25'h200 + 25'(i), 8'h70 + 8'(i), 1'b0);
    downloading = 1'b0;
    rdy_delay = 5;
    hold = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      cyc(1'b0, 25'd0, 8'd0, 1'b0);
      if (wlog.size() - base < 3) chk("busy_draining", 32'(dwnld_busy), 32'd1);
      else done = 1'b1;
    end
    chk("busy_drain_done", 32'(done), 32'd1);
    chk("busy_at_last_ack", 32'(dwnld_busy), 32'd1);
    cyc(1'b0, 25'd0, 8'd0, 1'b0);
    chk("busy_gap", 32'(dwnld_busy), 32'd1);
    cyc(1'b0, 25'd0, 8'd0, 1'b0);
    chk("busy_low_after_gap", 32'(dwnld_busy), 32'd0);

    // Reset during WRITE with four bytes queued
    downloading = 1'b1;
    rdy_delay = 1;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 25'h300 + 25'(i), 8'h90 + 8'(i), 1'b0);
    chk("pre_reset_writing", 32'(prog_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_we", 32'(prog_we), 32'd0);
    q.delete();
    m_ov = 0; m_prom_we = 0; dl_prev = 0; idle_run = 0; wcnt = 0;
    prog_rdy = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_busy", 32'(dwnld_busy), 32'd0);
    chk("reset_mask", 32'(prog_mask), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    base = wlog.size();
    cyc(1'b1, 25'h310, 8'h99, 1'b0);
    idle(20);
    chk("post_reset_no_write", 32'(wlog.size() - base), 32'd0);
    chk("post_reset_we_low", 32'(prog_we), 32'd0);
    downloading = 1'b1;
    cyc(1'b1, 25'h311, 8'h9A, 1'b0);
    idle(10);
    chk("post_reset_new_write", 32'(wlog.size() - base), 32'd1);
    if (wlog.size() > base) chk("post_reset_data", 32'(wlog[base].d), 32'h9A9A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
